spike_hazard: RTL and testbench

Player-side consumer of the spike hazard interface. Each `frame_clk` it tests the player's bounding box against every spike box, gated by that spike's `harm` flag. On a hit it decrements lives and runs a damage state machine: invulnerability window, death animation, game over, restart. It sits between the spike generator and the player and draw logic, and drives `hit_pulse`, `lives`, `blink` and `game_over` to them.

---
 rtl/spike_pkg.sv | 24 ++
 rtl/spike_hazard_box_overlap.sv | 21 ++
 rtl/spike_hazard.sv | 170 +++++++++++++++++
 tb/tb_spike_hazard.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/spike_pkg.sv
// Shared constants, state encoding and tile helper for the spike hazard path.
// The spike generator uses these same constants.
package spike_pkg;

    localparam int SPIKE_W     = 32;
    localparam int SPIKE_H     = 24;
    localparam int TILE_SHIFT  = 4;
    localparam int N_SPIKE_DEF = 3;

    typedef enum logic [1:0] {
        ALIVE     = 2'd0,
        INVULN    = 2'd1,
        DYING     = 2'd2,
        GAME_OVER = 2'd3
    } hazard_state_t;

    // Tile coordinate to 11-bit pixel coordinate; high bits beyond the screen drop off.
    function automatic logic [10:0] tile_to_px(input logic [9:0] tile);
        logic [10:0] wide;
        wide = 11'(tile);
        return wide << TILE_SHIFT;
    endfunction

endpackage

// File: rtl/spike_hazard_box_overlap.sv
// Combinational strict rectangle-intersection test on 11-bit pixel coordinates.
// Boxes that only share an edge do not overlap.
module box_overlap #(
    parameter int A_W = 16,
    parameter int A_H = 24,
    parameter int B_W = 32,
    parameter int B_H = 24
) (
    input  logic [10:0] ax,
    input  logic [10:0] ay,
    input  logic [10:0] bx,
    input  logic [10:0] by,
    output logic        overlap
);

    assign overlap = (ax < (bx + 11'(B_W))) &&
                     (bx < (ax + 11'(A_W))) &&
                     (ay < (by + 11'(B_H))) &&
                     (by < (ay + 11'(A_H)));

endmodule

// File: rtl/spike_hazard.sv
// Player-side spike collision check with lives counter and damage state machine
// (invulnerability window, death animation, game over, restart).
module spike_hazard
    import spike_pkg::*;
#(
    parameter int N_SPIKE       = N_SPIKE_DEF,
    parameter int LIVES         = 3,
    parameter int INVULN_FRAMES = 64,
    parameter int DEATH_FRAMES  = 32,
    parameter int PLAYER_W      = 16,
    parameter int PLAYER_H      = 24
) (
    input  logic       frame_clk,
    input  logic       RESET,
    input  logic [9:0] player_x,
    input  logic [9:0] player_y,
    input  logic [9:0] spike_row [N_SPIKE],
    input  logic [9:0] spike_col [N_SPIKE],
    input  logic       harm      [N_SPIKE],
    input  logic       restart,
    output logic [3:0] lives,
    output logic       hit_pulse,
    output logic [1:0] hit_idx,
    output logic       blink,
    output logic       dead,
    output logic       game_over
);

    localparam int MAX_FRAMES = (INVULN_FRAMES > DEATH_FRAMES) ? INVULN_FRAMES : DEATH_FRAMES;
    localparam int TW         = ($clog2(MAX_FRAMES) < 3) ? 3 : $clog2(MAX_FRAMES);
    localparam logic [TW-1:0] INV_LOAD   = TW'(INVULN_FRAMES - 1);
    localparam logic [TW-1:0] DEATH_LOAD = TW'(DEATH_FRAMES - 1);
    localparam logic [3:0]    LIVES_INIT = 4'(LIVES);

    logic [N_SPIKE-1:0] hit_s;
    logic               any_hit_s;
    logic [1:0]         hit_sel_s;

    hazard_state_t state_q, state_d;
    logic [3:0]    lives_q, lives_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          hit_pulse_q, hit_pulse_d;
    logic [1:0]    hit_idx_q, hit_idx_d;
    logic          blink_q, blink_d;
    logic          dead_q, dead_d;
    logic          game_over_q, game_over_d;

    // Row 0 would place the box above the screen, so it is treated as no spike.
    for (genvar g = 0; g < N_SPIKE; g++) begin : g_spike
        logic [10:0] sx_s;
        logic [10:0] sy_s;
        logic        ovl_s;

        assign sx_s = tile_to_px(spike_col[g]);
        assign sy_s = tile_to_px(spike_row[g] - 10'd1);

        box_overlap #(
            .A_W(PLAYER_W),
            .A_H(PLAYER_H),
            .B_W(SPIKE_W),
            .B_H(SPIKE_H)
        ) u_box (
            .ax     ({1'b0, player_x}),
            .ay     ({1'b0, player_y}),
            .bx     (sx_s),
            .by     (sy_s),
            .overlap(ovl_s)
        );

        assign hit_s[g] = harm[g] & ovl_s & (spike_row[g] != 10'd0);
    end

    // Priority encoder: lowest hitting index wins.
    always_comb begin
        any_hit_s = |hit_s;
        hit_sel_s = 2'd0;
        for (int i = N_SPIKE - 1; i >= 0; i--) begin
            hit_sel_s = hit_s[i] ? 2'(i) : hit_sel_s;
        end
    end

    // Next-state, lives, timer and output decode.
    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        timer_d     = timer_q;
        hit_pulse_d = 1'b0;
        hit_idx_d   = hit_idx_q;
        case (state_q)
            ALIVE: begin
                if (any_hit_s) begin
                    hit_pulse_d = 1'b1;
                    hit_idx_d   = hit_sel_s;
                    if (lives_q > 4'd1) begin
                        lives_d = lives_q - 4'd1;
                        state_d = INVULN;
                        timer_d = INV_LOAD;
                    end else begin
                        lives_d = 4'd0;
                        state_d = DYING;
                        timer_d = DEATH_LOAD;
                    end
                end else begin
                    state_d = ALIVE;
                end
            end
            INVULN: begin
                if (timer_q == '0) begin
                    state_d = ALIVE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            DYING: begin
                if (timer_q == '0) begin
                    state_d = GAME_OVER;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            GAME_OVER: begin
                // Collisions on the restart edge are deliberately not evaluated.
                if (restart) begin
                    lives_d   = LIVES_INIT;
                    hit_idx_d = 2'd0;
                    state_d   = ALIVE;
                end else begin
                    state_d = GAME_OVER;
                end
            end
            default: begin
                state_d = ALIVE;
            end
        endcase
        blink_d     = (state_d == INVULN) ? timer_d[2] : (state_d == DYING);
        dead_d      = (state_d == DYING);
        game_over_d = (state_d == GAME_OVER);
    end

    // State and registered outputs; reset discards any running timer.
    always_ff @(posedge frame_clk or negedge RESET) begin
        if (!RESET) begin
            state_q     <= ALIVE;
            lives_q     <= LIVES_INIT;
            timer_q     <= '0;
            hit_pulse_q <= 1'b0;
            hit_idx_q   <= 2'd0;
            blink_q     <= 1'b0;
            dead_q      <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            timer_q     <= timer_d;
            hit_pulse_q <= hit_pulse_d;
            hit_idx_q   <= hit_idx_d;
            blink_q     <= blink_d;
            dead_q      <= dead_d;
            game_over_q <= game_over_d;
        end
    end

    assign lives     = lives_q;
    assign hit_pulse = hit_pulse_q;
    assign hit_idx   = hit_idx_q;
    assign blink     = blink_q;
    assign dead      = dead_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_spike_hazard.sv
// Directed bench for spike_hazard: hit events go through a scoreboard queue checked
// by a monitor on every hit_pulse; state outputs are checked directly per frame.
module tb_spike_hazard;

    logic       frame_clk;
    logic       RESET;
    logic [9:0] player_x;
    logic [9:0] player_y;
    logic [9:0] spike_row [3];
    logic [9:0] spike_col [3];
    logic       harm      [3];
    logic       restart;
    logic [3:0] lives;
    logic       hit_pulse;
    logic [1:0] hit_idx;
    logic       blink;
    logic       dead;
    logic       game_over;

    typedef struct {
        logic [3:0] lives;
        logic [1:0] idx;
        int         cyc;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    spike_hazard dut (
        .frame_clk(frame_clk),
        .RESET    (RESET),
        .player_x (player_x),
        .player_y (player_y),
        .spike_row(spike_row),
        .spike_col(spike_col),
        .harm     (harm),
        .restart  (restart),
        .lives    (lives),
        .hit_pulse(hit_pulse),
        .hit_idx  (hit_idx),
        .blink    (blink),
        .dead     (dead),
        .game_over(game_over)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    always @(posedge frame_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every hit_pulse must match the oldest expected hit.
    always @(negedge frame_clk) begin
        if (hit_pulse === 1'b1) begin
            chk("sb_hit_expected", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_lives", 32'(lives), 32'(e.lives));
                chk("sb_hit_idx", 32'(hit_idx), 32'(e.idx));
                chk("sb_hit_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic expect_hit(input logic [3:0] l, input logic [1:0] idx, input int at_cyc);
        exp_t e;
        e.lives = l;
        e.idx   = idx;
        e.cyc   = at_cyc;
        sb_q.push_back(e);
    endtask

    task automatic place(input int x, input int y);
        player_x = 10'(x);
        player_y = 10'(y);
    endtask

    int k1;

    initial begin
        RESET   = 1'b1;
        restart = 1'b0;
        place(400, 400);
        for (int i = 0; i < 3; i++) begin
            spike_row[i] = 10'd0;
            spike_col[i] = 10'd0;
            harm[i]      = 1'b0;
        end
        #2 RESET = 1'b0;
        #1;
        chk("rst_lives", 32'(lives), 32'd3);
        chk("rst_hit_pulse", 32'(hit_pulse), 32'd0);
        chk("rst_hit_idx", 32'(hit_idx), 32'd0);
        chk("rst_blink", 32'(blink), 32'd0);
        chk("rst_dead", 32'(dead), 32'd0);
        chk("rst_game_over", 32'(game_over), 32'd0);
        tick();
        RESET = 1'b1;
        tick();

        // Spike0 box: x 160..191, y 176..199.
        spike_row[0] = 10'd12;
        spike_col[0] = 10'd10;
        harm[0]      = 1'b1;
        place(192, 180);            // touches right edge
        repeat (3) tick();
        chk("edge_right_lives", 32'(lives), 32'd3);
        place(144, 180);            // touches left edge
        repeat (3) tick();
        chk("edge_left_lives", 32'(lives), 32'd3);
        place(170, 152);            // touches top edge
        repeat (3) tick();
        chk("edge_top_lives", 32'(lives), 32'd3);
        harm[0] = 1'b0;
        place(175, 180);            // overlaps, not harmful
        repeat (3) tick();
        chk("harm_gate_lives", 32'(lives), 32'd3);
        chk("harm_gate_blink", 32'(blink), 32'd0);

        // Basic hit, then hold overlap through the whole window.
        harm[0] = 1'b1;
        place(170, 180);
        expect_hit(4'd2, 2'd0, cyc + 1);
        tick();
        k1 = cyc;
        chk("hit1_lives", 32'(lives), 32'd2);
        chk("hit1_pulse", 32'(hit_pulse), 32'd1);
        chk("hit1_idx", 32'(hit_idx), 32'd0);
        chk("hit1_blink", 32'(blink), 32'd1);
        expect_hit(4'd1, 2'd0, k1 + 65);
        for (int j = 1; j <= 64; j++) begin
            tick();
            chk("inv_blink", 32'(blink), (j <= 63) ? 32'(((63 - j) >> 2) & 1) : 32'd0);
            chk("inv_lives", 32'(lives), 32'd2);
            chk("inv_pulse", 32'(hit_pulse), 32'd0);
        end
        tick();
        chk("hit2_lives", 32'(lives), 32'd1);
        chk("hit2_pulse", 32'(hit_pulse), 32'd1);

        place(400, 400);
        repeat (66) tick();
        chk("alive_lives", 32'(lives), 32'd1);
        chk("alive_blink", 32'(blink), 32'd0);

        // Last life taken by spike2 only.
        harm[0]      = 1'b0;
        spike_row[2] = 10'd12;
        spike_col[2] = 10'd10;
        harm[2]      = 1'b1;
        place(170, 180);
        expect_hit(4'd0, 2'd2, cyc + 1);
        tick();
        chk("die_lives", 32'(lives), 32'd0);
        chk("die_dead", 32'(dead), 32'd1);
        chk("die_blink", 32'(blink), 32'd1);
        for (int j = 1; j <= 32; j++) begin
            tick();
            chk("dying_dead", 32'(dead), 32'(j <= 31));
            chk("dying_game_over", 32'(game_over), 32'(j == 32));
            chk("dying_blink", 32'(blink), 32'(j <= 31));
        end
        repeat (3) tick();
        chk("go_hold", 32'(game_over), 32'd1);
        chk("go_lives", 32'(lives), 32'd0);
        chk("go_hit_idx", 32'(hit_idx), 32'd2);
        restart = 1'b1;             // overlap still present on this edge
        tick();
        chk("restart_lives", 32'(lives), 32'd3);
        chk("restart_game_over", 32'(game_over), 32'd0);
        chk("restart_dead", 32'(dead), 32'd0);
        chk("restart_pulse", 32'(hit_pulse), 32'd0);
        chk("restart_hit_idx", 32'(hit_idx), 32'd0);
        restart = 1'b0;
        place(400, 400);
        repeat (2) tick();
        chk("post_restart_lives", 32'(lives), 32'd3);

        // Simultaneous hit on spike0 and spike2.
        harm[0] = 1'b1;
        place(170, 180);
        expect_hit(4'd2, 2'd0, cyc + 1);
        tick();
        chk("simul_lives", 32'(lives), 32'd2);
        chk("simul_idx", 32'(hit_idx), 32'd0);
        place(400, 400);
        repeat (23) tick();         // timer now 40
        chk("pre_rst_lives", 32'(lives), 32'd2);
        #2 RESET = 1'b0;
        #1;
        chk("midrst_lives", 32'(lives), 32'd3);
        chk("midrst_blink", 32'(blink), 32'd0);
        chk("midrst_dead", 32'(dead), 32'd0);
        @(negedge frame_clk);
        RESET = 1'b1;
        tick();

        // Priority: spike1 and spike2 hit, spike0 harmless.
        harm[0]      = 1'b0;
        spike_row[1] = 10'd12;
        spike_col[1] = 10'd10;
        harm[1]      = 1'b1;
        place(170, 180);
        expect_hit(4'd2, 2'd1, cyc + 1);
        tick();
        chk("prio_lives", 32'(lives), 32'd2);
        chk("prio_idx", 32'(hit_idx), 32'd1);
        place(400, 400);
        repeat (2) tick();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
